// File: rtl/core_seq.sv
// Instruction sequencer for the systolic core: steps one convolution layer
// (per-kij kernel/activation/execute/drain, then per-pixel accumulation).
module core_seq #(
  parameter int                ROW    = 8,
  parameter int                COL    = 8,
  parameter int                IN_W   = 6,
  parameter int                KSZ    = 3,
  parameter int                GAP    = 10,
  parameter int                ADDR_W = 11,
  parameter logic [ADDR_W-1:0] W_BASE = 'h400,
  parameter logic [ADDR_W-1:0] A_BASE = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic [1:0]  mode_q,
  output logic        core_clr,
  output logic        busy,
  output logic        out_valid,
  output logic        done
);

  localparam int LEN_NIJ = IN_W * IN_W;
  localparam int LEN_KIJ = KSZ * KSZ;
  localparam int OUT_W   = IN_W - KSZ + 1;
  localparam int LEN_OUT = OUT_W * OUT_W;
  localparam int CW      = 16;

  localparam logic [CW-1:0]     T_COL     = CW'(COL);
  localparam logic [CW-1:0]     T_KLD_END = CW'(COL - 1);
  localparam logic [CW-1:0]     T_GAP_END = CW'(GAP - 1);
  localparam logic [CW-1:0]     T_NIJ     = CW'(LEN_NIJ);
  localparam logic [CW-1:0]     T_EXE_END = CW'(LEN_NIJ + ROW + COL - 1);
  localparam logic [CW-1:0]     T_KIJ     = CW'(LEN_KIJ);
  localparam logic [CW-1:0]     T_ONE     = CW'(1);
  localparam logic [7:0]        K_LAST    = 8'(LEN_KIJ - 1);
  localparam logic [7:0]        O_LAST    = 8'(LEN_OUT - 1);
  localparam logic [7:0]        KC_LAST   = 8'(KSZ - 1);
  localparam logic [7:0]        OC_LAST   = 8'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] COL_A     = ADDR_W'(COL);
  localparam logic [ADDR_W-1:0] NIJ_A     = ADDR_W'(LEN_NIJ);
  localparam logic [ADDR_W-1:0] STEP_KC   = ADDR_W'(LEN_NIJ + 1);
  localparam logic [ADDR_W-1:0] STEP_KR   = ADDR_W'(LEN_NIJ + IN_W - KSZ + 1);
  localparam logic [ADDR_W-1:0] STEP_OROW = ADDR_W'(KSZ);
  localparam logic [33:0]       IDLE_INST = 34'h1_800C_0000;

  generate
    if (LEN_KIJ * LEN_NIJ > (1 << ADDR_W)) begin : g_psum_fit
      $error("core_seq: len_kij*len_nij exceeds pmem address space");
    end
    if (ADDR_W != 11 || GAP < 1) begin : g_param_chk
      $error("core_seq: inst field map needs ADDR_W=11 and GAP>=1");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_KRD, S_KLD, S_GAP, S_AWR, S_EXE, S_DRN,
    S_ACLR, S_AACC, S_AOUT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       t_q, t_d;
  logic [7:0]          kij_q, kij_d, o_q, o_d, ocol_q, ocol_d, kc_q, kc_d;
  logic [ADDR_W-1:0]   kbase_q, kbase_d, pbase_q, pbase_d;
  logic [ADDR_W-1:0]   obase_q, obase_d, aaddr_q, aaddr_d;
  logic                wdone_q, wdone_d;
  logic [1:0]          mode_d;
  logic [33:0]         inst_q, inst_d;
  logic                clr_d, busy_d, ov_d, done_d;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    kij_d   = kij_q;
    kbase_d = kbase_q;
    pbase_d = pbase_q;
    o_d     = o_q;
    ocol_d  = ocol_q;
    obase_d = obase_q;
    kc_d    = kc_q;
    aaddr_d = aaddr_q;
    wdone_d = wdone_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CLR;
        mode_d  = mode;
        kij_d   = '0;
        kbase_d = '0;
        pbase_d = '0;
        t_d     = '0;
      end
      S_CLR: begin
        state_d = S_KRD;
        t_d     = '0;
      end
      S_KRD: if (t_q == T_COL) begin state_d = S_KLD; t_d = '0; end
             else t_d = t_q + T_ONE;
      S_KLD: if (t_q == T_KLD_END) begin state_d = S_GAP; t_d = '0; end
             else t_d = t_q + T_ONE;
      S_GAP: if (t_q == T_GAP_END) begin state_d = S_AWR; t_d = '0; end
             else t_d = t_q + T_ONE;
      S_AWR: if (t_q == T_NIJ) begin state_d = S_EXE; t_d = '0; end
             else t_d = t_q + T_ONE;
      S_EXE: if (t_q == T_EXE_END) begin
        state_d = S_DRN;
        t_d     = '0;
        wdone_d = 1'b0;
      end else t_d = t_q + T_ONE;
      S_DRN: begin
        if (t_q == T_NIJ) begin
          t_d     = '0;
          wdone_d = 1'b0;
          if (kij_q == K_LAST) begin
            state_d = S_ACLR;
            o_d     = '0;
            ocol_d  = '0;
            obase_d = '0;
          end else begin
            state_d = S_CLR;
            kij_d   = kij_q + 8'd1;
            kbase_d = kbase_q + COL_A;
            pbase_d = pbase_q + NIJ_A;
          end
        end else if (!ofifo_valid) begin
          // Held drain index: the pending pmem write went out this cycle.
          wdone_d = 1'b1;
        end else begin
          t_d     = t_q + T_ONE;
          wdone_d = 1'b0;
        end
      end
      S_ACLR: begin
        state_d = S_AACC;
        t_d     = '0;
        kc_d    = '0;
        aaddr_d = obase_q;
      end
      S_AACC: begin
        if (t_q == T_KIJ) begin
          state_d = S_AOUT;
          t_d     = '0;
        end else begin
          t_d = t_q + T_ONE;
          if (kc_q == KC_LAST) begin
            kc_d    = '0;
            aaddr_d = aaddr_q + STEP_KR;
          end else begin
            kc_d    = kc_q + 8'd1;
            aaddr_d = aaddr_q + STEP_KC;
          end
        end
      end
      S_AOUT: begin
        if (o_q == O_LAST) state_d = S_DONE;
        else begin
          state_d = S_ACLR;
          o_d     = o_q + 8'd1;
          if (ocol_q == OC_LAST) begin
            ocol_d  = '0;
            obase_d = obase_q + STEP_OROW;
          end else begin
            ocol_d  = ocol_q + 8'd1;
            obase_d = obase_q + ONE_A;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Output word for the state being entered, so inst lines up with state_q.
    inst_d = IDLE_INST;
    clr_d  = 1'b0;
    ov_d   = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    case (state_d)
      S_CLR, S_ACLR: clr_d = 1'b1;
      S_KRD: begin
        if (t_d < T_COL) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = W_BASE + kbase_d + t_d[ADDR_W-1:0];
        end
        if (t_d != '0) begin
          if (mode_d[1]) inst_d[5] = 1'b1;
          else           inst_d[2] = 1'b1;
        end
      end
      S_KLD: begin
        inst_d[0] = 1'b1;
        if (mode_d[1]) inst_d[4] = 1'b1;
        else           inst_d[3] = 1'b1;
      end
      S_AWR: begin
        if (t_d < T_NIJ) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = A_BASE + t_d[ADDR_W-1:0];
        end
        if (t_d != '0) inst_d[2] = 1'b1;
      end
      S_EXE: if (t_d < T_NIJ) begin
        inst_d[1] = 1'b1;
        inst_d[3] = 1'b1;
      end
      S_DRN: begin
        if (t_d < T_NIJ) inst_d[6] = 1'b1;
        if (t_d != '0 && !wdone_d) begin
          inst_d[32]    = 1'b0;
          inst_d[31]    = 1'b0;
          inst_d[30:20] = pbase_d + t_d[ADDR_W-1:0] - ONE_A;
        end
      end
      S_AACC: begin
        if (t_d < T_KIJ) begin
          inst_d[32]    = 1'b0;
          inst_d[30:20] = aaddr_d;
        end
        if (t_d != '0) inst_d[33] = 1'b1;
      end
      S_AOUT:  ov_d   = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      kij_q     <= '0;
      kbase_q   <= '0;
      pbase_q   <= '0;
      o_q       <= '0;
      ocol_q    <= '0;
      obase_q   <= '0;
      kc_q      <= '0;
      aaddr_q   <= '0;
      wdone_q   <= 1'b0;
      mode_q    <= 2'b00;
      inst_q    <= IDLE_INST;
      core_clr  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      kij_q     <= kij_d;
      kbase_q   <= kbase_d;
      pbase_q   <= pbase_d;
      o_q       <= o_d;
      ocol_q    <= ocol_d;
      obase_q   <= obase_d;
      kc_q      <= kc_d;
      aaddr_q   <= aaddr_d;
      wdone_q   <= wdone_d;
      mode_q    <= mode_d;
      inst_q    <= inst_d;
      core_clr  <= clr_d;
      busy      <= busy_d;
      out_valid <= ov_d;
      done      <= done_d;
    end
  end

  // The ofifo read is only issued while the core reports data available.
  assign inst = {inst_q[33:7], inst_q[6] & ofifo_valid, inst_q[5:0]};

endmodule
